// File: rtl/fmap_pkg.sv
// -----------------------------------------------------------------------------
// fmap_pkg
//   Shared definitions for the packed feature-map stream blocks.
//   - FP32_WIDTH / DEFAULT_NUM_CH / DEFAULT_IMG_SIZE : default geometry
//   - pack_state_e : pixel packer control states
//   - ch_slot_lsb() : bit offset of a channel slot inside a packed pixel
// -----------------------------------------------------------------------------
package fmap_pkg;

  localparam int unsigned FP32_WIDTH       = 32;
  localparam int unsigned DEFAULT_NUM_CH   = 32;
  localparam int unsigned DEFAULT_IMG_SIZE = 104;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } pack_state_e;

  // Channel c of a packed pixel occupies [data_width*c +: data_width].
  function automatic int unsigned ch_slot_lsb(input int unsigned data_width,
                                              input int unsigned ch);
    return data_width * ch;
  endfunction

endpackage

// File: rtl/fmap_raster_counter.sv
// -----------------------------------------------------------------------------
// fmap_raster_counter
//   Column/row raster position for a SIZE x SIZE frame. Advances one pixel per
//   i_adv, column wraps at SIZE-1 into the next row, row wraps at SIZE-1.
//   Ports:
//     i_clk, i_rst_n    : clock, asynchronous active-low reset
//     i_clr             : return to position (0,0)
//     i_adv             : step to the next raster position
//     o_col, o_row      : current position
//     o_row_last        : current position is the last column of its row
//     o_frame_last      : current position is the last pixel of the frame
// -----------------------------------------------------------------------------
module fmap_raster_counter #(
  parameter  int unsigned SIZE = 104,
  localparam int unsigned CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_row_last,
  output logic          o_frame_last
);

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_row_last   = (r_col == LAST);
  assign o_frame_last = (r_col == LAST) && (r_row == LAST);

endmodule

// File: rtl/fmap_pixel_packer.sv
// -----------------------------------------------------------------------------
// fmap_pixel_packer
//   Packs NUM_CH channel-serial DATA_WIDTH words into one OUT_WIDTH pixel and
//   emits one IMG_SIZE x IMG_SIZE frame per start command in raster order.
//   Optional macro FMAP_PACK_ZERO_PAD_EN: emit an (IMG_SIZE+2)^2 frame with an
//   all-zero one-pixel border generated internally (in_ready low on border).
//   Ports:
//     Clk, Rst       : clock, asynchronous active-low reset
//     start          : begin a frame (sampled only in IDLE)
//     in_data/valid  : channel word input; in_ready = can accept this cycle
//     data_out       : packed pixel, channel c at [DATA_WIDTH*c +: DATA_WIDTH]
//     valid_out      : one-cycle pulse per pixel, qualifies row_last/frame_last
//     busy           : high from start acceptance through the DONE cycle
//     done           : one-cycle pulse alongside the frame's final pixel
// -----------------------------------------------------------------------------
module fmap_pixel_packer
  import fmap_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FP32_WIDTH,
  parameter  int unsigned NUM_CH     = DEFAULT_NUM_CH,
  parameter  int unsigned IMG_SIZE   = DEFAULT_IMG_SIZE,
  localparam int unsigned OUT_WIDTH  = DATA_WIDTH * NUM_CH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  valid_out,
  output logic                  row_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done
);

`ifdef FMAP_PACK_ZERO_PAD_EN
  localparam int unsigned OUT_SIZE = IMG_SIZE + 2;
`else
  localparam int unsigned OUT_SIZE = IMG_SIZE;
`endif
  localparam int unsigned PW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);
  localparam logic [PW:0]    POS_LIMIT = (PW + 1)'(OUT_SIZE);
`ifdef FMAP_PACK_ZERO_PAD_EN
  localparam logic [PW-1:0]  COL_PENULT = PW'(OUT_SIZE - 2);
  localparam logic [PW-1:0]  ROW_LAST   = PW'(OUT_SIZE - 1);
`endif

  pack_state_e           r_state;
  logic [CHW-1:0]        r_ch;
  logic [OUT_WIDTH-1:0]  r_fill;
  logic [OUT_WIDTH-1:0]  r_data_out;
  logic                  r_valid_out;
  logic                  r_row_last;
  logic                  r_frame_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_adv;
  logic                  w_clr;
  logic [PW-1:0]         w_col;
  logic [PW-1:0]         w_row;
  logic                  w_row_last;
  logic                  w_frame_last;
  logic [OUT_WIDTH-1:0]  w_pixel;

  assign in_ready = (r_state == FILL);
  assign w_accept = in_valid & in_ready;
  assign w_clr    = (r_state == IDLE) & start;
  // One raster step per emitted pixel: a completed fill or a border pixel.
  assign w_adv    = ((r_state == FILL) & w_accept & (r_ch == CH_LAST)) |
                    (r_state == PAD);

  // Fill register with the incoming word merged into its slot, so the last
  // channel can be forwarded to data_out in the same cycle it is accepted.
  always_comb begin
    w_pixel = r_fill;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (r_ch == CHW'(c)) begin
        w_pixel[ch_slot_lsb(DATA_WIDTH, c) +: DATA_WIDTH] = in_data;
      end
    end
  end

`ifdef FMAP_PACK_ZERO_PAD_EN
  logic w_pad_to_fill;
  // From a border pixel, the next position is interior only when it stays in
  // this row, is not the right border and the row is not top/bottom.
  assign w_pad_to_fill = !w_row_last && (w_col != COL_PENULT) &&
                         (w_row != '0) && (w_row != ROW_LAST);
`endif

  fmap_raster_counter #(
    .SIZE (OUT_SIZE)
  ) u_raster (
    .i_clk        (Clk),
    .i_rst_n      (Rst),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_row_last   (w_row_last),
    .o_frame_last (w_frame_last)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_fill       <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_row_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_row_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_ch   <= '0;
`ifdef FMAP_PACK_ZERO_PAD_EN
            r_state <= PAD;
`else
            r_state <= FILL;
`endif
          end
        end
        FILL: begin
          if (w_accept) begin
            r_fill <= w_pixel;
            if (r_ch == CH_LAST) begin
              r_ch         <= '0;
              r_data_out   <= w_pixel;
              r_valid_out  <= 1'b1;
              r_row_last   <= w_row_last;
              r_frame_last <= w_frame_last;
              if (w_frame_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
`ifdef FMAP_PACK_ZERO_PAD_EN
              else if (w_col == COL_PENULT) begin
                r_state <= PAD;
              end
`endif
            end else begin
              r_ch <= r_ch + CHW'(1);
            end
          end
        end
`ifdef FMAP_PACK_ZERO_PAD_EN
        PAD: begin
          r_data_out   <= '0;
          r_valid_out  <= 1'b1;
          r_row_last   <= w_row_last;
          r_frame_last <= w_frame_last;
          if (w_frame_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_pad_to_fill) begin
            r_state <= FILL;
          end
        end
`endif
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign row_last   = r_row_last;
  assign frame_last = r_frame_last;
  assign busy       = r_busy;
  assign done       = r_done;

  a_pos_in_range: assert property (@(posedge Clk) disable iff (!Rst)
    ({1'b0, w_col} < POS_LIMIT) && ({1'b0, w_row} < POS_LIMIT));

endmodule

// File: tb/tb_fmap_pixel_packer.sv
`timescale 1ns/1ps
module tb_fmap_pixel_packer;

  localparam int DW     = 32;
  localparam int NCH    = 4;
  localparam int IMG    = 4;
  localparam int OW     = DW * NCH;
`ifdef FMAP_PACK_ZERO_PAD_EN
  localparam int PADB   = 1;
`else
  localparam int PADB   = 0;
`endif
  localparam int OSZ    = IMG + 2 * PADB;
  localparam int NPIX   = OSZ * OSZ;
  localparam int NWORDS = IMG * IMG * NCH;
  localparam int PIX0   = PADB * (OSZ + 1);

  typedef logic [OW+1:0] cval_t;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] data_out;
  logic          valid_out, row_last, frame_last, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fmap_pixel_packer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .IMG_SIZE   (IMG)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .row_last   (row_last),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          rl;
    logic          fl;
    int            cyc;
  } pix_t;

  typedef struct {
    string name;
    int    gap_mode;     // 0 back-to-back, 1 toggle 1/0, 2 random gaps
    int    spur_at;      // word index at which a stray start is pulsed, -1 none
    bit    rand_data;
    int    exp_pix;
    int    exp_spacing;  // cycles between pulses, -1 when not uniform
  } scen_t;

  pix_t          got[$];
  pix_t          exp_q[$];
  int            acc_cyc[$];
  logic [DW-1:0] words[$];
  int            cyc = 0;
  int            done_cnt = 0;
  bit            unstable = 1'b0;
  logic [OW-1:0] prev_data = '0;
  scen_t         tbl[4];

  task automatic check(input string name, input cval_t got_v, input cval_t exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got_v, exp_v);
    end
  endtask

  // Output monitor: sampled on the falling edge, mid-cycle.
  always @(negedge Clk) begin
    cyc++;
    if (valid_out) got.push_back('{data_out, row_last, frame_last, cyc});
    else if (data_out !== prev_data) unstable = 1'b1;
    prev_data = data_out;
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (done) begin
      done_cnt++;
      check("done_with_final_pixel", cval_t'({valid_out, frame_last}), cval_t'(2'b11));
    end
  end

  task automatic fill_words(input bit rnd);
    words.delete();
    for (int i = 0; i < NWORDS; i++)
      words.push_back(rnd ? DW'($urandom) : DW'((i / NCH) * 16 + (i % NCH)));
  endtask

  // Expected frame from the raster rules: padded grid, interior copied from
  // consecutive groups of NCH input words, border all zero.
  task automatic build_model();
    exp_q.delete();
    for (int r = 0; r < OSZ; r++) begin
      for (int c = 0; c < OSZ; c++) begin
        pix_t p;
        int ir, ic;
        ir = r - PADB;
        ic = c - PADB;
        p.data = '0;
        if (ir >= 0 && ir < IMG && ic >= 0 && ic < IMG)
          for (int k = 0; k < NCH; k++) p.data[k*DW +: DW] = words[(ir*IMG + ic)*NCH + k];
        p.rl  = (c == OSZ - 1);
        p.fl  = (r == OSZ - 1) && (c == OSZ - 1);
        p.cyc = 0;
        exp_q.push_back(p);
      end
    end
  endtask

  // Called and returns one time unit after a rising edge.
  task automatic start_frame();
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_words(input int n, input int mode, input int spur_at, output int taken);
    int guard, t;
    bit v, acc;
    taken = 0; guard = 0; t = 0;
    while (taken < n && guard < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = words[taken];
      start    = (taken == spur_at);
      acc      = v && in_ready;
      @(posedge Clk); #1;
      if (acc) taken++;
      guard++; t++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_scen(input scen_t s);
    int taken, guard, r, c, ip, li;
    fill_words(s.rand_data);
    build_model();
    got.delete(); acc_cyc.delete();
    done_cnt = 0; unstable = 1'b0; prev_data = data_out;
    start_frame();
    check({s.name, "_busy_after_start"}, cval_t'(busy), cval_t'(1));
    drive_words(NWORDS, s.gap_mode, s.spur_at, taken);
    check({s.name, "_words_taken"}, cval_t'(taken), cval_t'(NWORDS));
    guard = 0;
    while (done_cnt == 0 && guard < 200) begin
      @(posedge Clk); #1;
      guard++;
    end
    check({s.name, "_done_count"}, cval_t'(done_cnt), cval_t'(1));
    check({s.name, "_idle_after_done"}, cval_t'({busy, in_ready}), cval_t'(0));
    check({s.name, "_accepts"}, cval_t'(acc_cyc.size()), cval_t'(NWORDS));
    check({s.name, "_pixel_count"}, cval_t'(got.size()), cval_t'(s.exp_pix));
    check({s.name, "_data_stable"}, cval_t'(unstable), cval_t'(0));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_pix%0d", s.name, i),
            cval_t'({got[i].data, got[i].rl, got[i].fl}),
            cval_t'({exp_q[i].data, exp_q[i].rl, exp_q[i].fl}));
      r = i / OSZ;
      c = i % OSZ;
      if (r >= PADB && r < PADB + IMG && c >= PADB && c < PADB + IMG) begin
        ip = (r - PADB) * IMG + (c - PADB);
        li = ip * NCH + NCH - 1;
        if (li < acc_cyc.size())
          check($sformatf("%s_latency%0d", s.name, i), cval_t'(got[i].cyc), cval_t'(acc_cyc[li] + 1));
      end
      if (s.exp_spacing > 0 && i > 0)
        check($sformatf("%s_spacing%0d", s.name, i),
              cval_t'(got[i].cyc - got[i-1].cyc), cval_t'(s.exp_spacing));
    end
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int taken;
    tbl[0] = '{"b2b",    0, -1, 1'b0, NPIX, (PADB != 0) ? -1 : 4};
    tbl[1] = '{"toggle", 1, -1, 1'b0, NPIX, (PADB != 0) ? -1 : 8};
    tbl[2] = '{"spur",   0, 10, 1'b0, NPIX, (PADB != 0) ? -1 : 4};
    tbl[3] = '{"random", 2, -1, 1'b1, NPIX, -1};

    // Reset state
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_data_out", cval_t'(data_out), cval_t'(0));
    check("reset_flags", cval_t'({valid_out, row_last, frame_last, busy, done, in_ready}), cval_t'(0));
    Rst = 1'b1;
    @(posedge Clk); #1;

    // in_valid while IDLE is not consumed
    got.delete(); acc_cyc.delete();
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("idle_in_ready%0d", i), cval_t'(in_ready), cval_t'(0));
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    check("idle_nothing_taken", cval_t'(acc_cyc.size()), cval_t'(0));
    check("idle_no_pixels", cval_t'(got.size()), cval_t'(0));

    for (int i = 0; i < 4; i++) run_scen(tbl[i]);

    // Asynchronous reset mid-frame after 6 accepts
    fill_words(1'b0);
    start_frame();
    drive_words(6, 0, -1, taken);
    check("midrst_words_taken", cval_t'(taken), cval_t'(6));
    #2;
    Rst = 1'b0;
    #1;
    check("midrst_data_out", cval_t'(data_out), cval_t'(0));
    check("midrst_flags", cval_t'({valid_out, row_last, frame_last, busy, done, in_ready}), cval_t'(0));
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    run_scen(tbl[0]);
    if (got.size() > PIX0)
      check("post_reset_first_pixel", cval_t'(got[PIX0].data),
            cval_t'(128'h00000003_00000002_00000001_00000000));
    else
      check("post_reset_first_pixel_present", cval_t'(got.size()), cval_t'(PIX0 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
